cache_ctrl_fsm: RTL and testbench

- Controller stage directly upstream of the cache_line storage. It accepts CPU read/write requests and drives the line's try_read, try_write and cache_write strobes.
- It handles write-back of dirty victims and allocation from main memory (write-back, write-allocate, single direct-mapped line).
- It returns read data to the CPU and keeps saturating hit/miss statistics counters.

---
 rtl/cache_ctrl_fsm.sv | 128 ++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// Write-back, write-allocate controller for a single direct-mapped cache line.
// Sequences CPU requests through probe, dirty write-back and fill, and keeps hit/miss statistics.
module cache_ctrl_fsm #(
    parameter int ADDRESS_WORD_SIZE = 32,
    parameter int TAG_SIZE          = 19,
    parameter int WORD_SIZE         = 8,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         cpu_req_valid,
    input  logic                         cpu_req_rw,
    input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]         cpu_wdata,
    output logic                         cpu_ready,
    output logic                         cpu_resp_valid,
    output logic [WORD_SIZE-1:0]         cpu_rdata,
    output logic [ADDRESS_WORD_SIZE-1:0] line_addr,
    output logic                         line_try_read,
    output logic                         line_try_write,
    output logic                         line_cache_write,
    output logic [WORD_SIZE-1:0]         line_write_data,
    input  logic                         line_hit,
    input  logic                         line_valid,
    input  logic                         line_dirty,
    input  logic [WORD_SIZE-1:0]         line_data_out,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]         mem_wdata,
    input  logic                         mem_ready,
    input  logic [WORD_SIZE-1:0]         mem_rdata,
    output logic [CNT_WIDTH-1:0]         hit_cnt,
    output logic [CNT_WIDTH-1:0]         miss_cnt
);
    localparam int INDEX_W = ADDRESS_WORD_SIZE - TAG_SIZE;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        RESPOND
    } state_t;

    state_t                         state_reg;
    logic [ADDRESS_WORD_SIZE-1:0]   addr_reg;
    logic                           rw_reg;
    logic [WORD_SIZE-1:0]           wdata_reg;
    logic                           first_cmp_reg;
    logic [TAG_SIZE-1:0]            victim_tag_reg;
    logic [WORD_SIZE-1:0]           rdata_reg;
    logic [CNT_WIDTH-1:0]           hit_cnt_reg;
    logic [CNT_WIDTH-1:0]           miss_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            rw_reg         <= 1'b0;
            wdata_reg      <= '0;
            first_cmp_reg  <= 1'b0;
            victim_tag_reg <= '0;
            rdata_reg      <= '0;
            hit_cnt_reg    <= '0;
            miss_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_req_valid) begin
                        addr_reg      <= cpu_addr;
                        rw_reg        <= cpu_req_rw;
                        wdata_reg     <= cpu_wdata;
                        first_cmp_reg <= 1'b1;
                        state_reg     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (line_hit) begin
                        if (!rw_reg)
                            rdata_reg <= line_data_out;
                        if (first_cmp_reg && (hit_cnt_reg != '1))
                            hit_cnt_reg <= hit_cnt_reg + CNT_ONE;
                        state_reg <= RESPOND;
                    end else begin
                        // Only the first probe of a request is counted; the post-fill re-probe is not.
                        if (first_cmp_reg && (miss_cnt_reg != '1))
                            miss_cnt_reg <= miss_cnt_reg + CNT_ONE;
                        first_cmp_reg <= 1'b0;
                        state_reg     <= (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready)
                        state_reg <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        victim_tag_reg <= addr_reg[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
                        state_reg      <= COMPARE;
                    end
                end
                RESPOND: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cpu_ready        = (state_reg == IDLE);
    assign cpu_resp_valid   = (state_reg == RESPOND);
    assign cpu_rdata        = rdata_reg;

    assign line_addr        = addr_reg;
    assign line_try_read    = (state_reg == COMPARE) && !rw_reg;
    assign line_try_write   = (state_reg == COMPARE) && rw_reg;
    // The fill lands in the same cycle memory hands over the word.
    assign line_cache_write = (state_reg == ALLOCATE) && mem_ready;
    assign line_write_data  = (state_reg == ALLOCATE) ? mem_rdata : wdata_reg;

    assign mem_req   = (state_reg == WRITEBACK) || (state_reg == ALLOCATE);
    assign mem_we    = (state_reg == WRITEBACK);
    assign mem_addr  = (state_reg == WRITEBACK) ? {victim_tag_reg, addr_reg[INDEX_W-1:0]} : addr_reg;
    assign mem_wdata = line_data_out;

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with a behavioural single-line cache and a wait-state memory.
// Counters are built 8 bits wide so saturation is reachable in a short run.
module tb_cache_ctrl_fsm;
    localparam int AW = 32;
    localparam int TW = 19;
    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_b = 1'b1;
    logic          cpu_req_valid = 1'b0;
    logic          cpu_req_rw = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [W-1:0]  cpu_wdata = '0;
    logic          cpu_ready, cpu_resp_valid;
    logic [W-1:0]  cpu_rdata;
    logic [AW-1:0] line_addr;
    logic          line_try_read, line_try_write, line_cache_write;
    logic [W-1:0]  line_write_data;
    logic          line_hit, line_valid, line_dirty;
    logic [W-1:0]  line_data_out;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata, mem_rdata;
    logic [CW-1:0] hit_cnt, miss_cnt;

    cache_ctrl_fsm #(
        .ADDRESS_WORD_SIZE(AW), .TAG_SIZE(TW), .WORD_SIZE(W), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata(cpu_rdata), .line_addr(line_addr), .line_try_read(line_try_read),
        .line_try_write(line_try_write), .line_cache_write(line_cache_write),
        .line_write_data(line_write_data), .line_hit(line_hit), .line_valid(line_valid),
        .line_dirty(line_dirty), .line_data_out(line_data_out), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural cache line: combinational hit, writes on the clock edge.
    logic          lv = 1'b0, ld = 1'b0;
    logic [TW-1:0] ltag = '0;
    logic [W-1:0]  ldata = '0;
    assign line_hit      = lv && (ltag == line_addr[AW-1 -: TW]);
    assign line_valid    = lv;
    assign line_dirty    = ld;
    assign line_data_out = ldata;
    always @(posedge clk) begin
        if (rst_b) begin
            lv <= 1'b0; ld <= 1'b0; ltag <= '0; ldata <= '0;
        end else if (line_cache_write) begin
            lv <= 1'b1; ld <= 1'b0; ltag <= line_addr[AW-1 -: TW]; ldata <= line_write_data;
        end else if (line_try_write && line_hit) begin
            ld <= 1'b1; ldata <= line_write_data;
        end
    end

    // Memory: completes after mem_wait_cfg wait cycles of a held request.
    int           mem_wait_cfg = 0;
    logic [W-1:0] mem_fetch_data = '0;
    int           wait_cnt = 0;
    assign mem_ready = mem_req && (wait_cnt >= mem_wait_cfg);
    assign mem_rdata = mem_fetch_data;
    always @(posedge clk) begin
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            wb_n = 0, fetch_n = 0, fill_n = 0, tw_n = 0, memcyc_n = 0, resp_n = 0;
    int            acc_cyc = 0, resp_cyc = 0, wb_cyc = 0, fetch_cyc = 0;
    logic [AW-1:0] wb_addr = '0, fetch_addr = '0;
    logic [W-1:0]  wb_data = '0, resp_rdata = '0;
    always @(negedge clk) begin
        if (!rst_b) begin
            if (mem_req) memcyc_n <= memcyc_n + 1;
            if (mem_req && mem_ready && mem_we) begin
                wb_n <= wb_n + 1; wb_addr <= mem_addr; wb_data <= mem_wdata; wb_cyc <= cyc;
            end
            if (mem_req && mem_ready && !mem_we) begin
                fetch_n <= fetch_n + 1; fetch_addr <= mem_addr; fetch_cyc <= cyc;
            end
            if (line_cache_write) fill_n <= fill_n + 1;
            if (line_try_write) tw_n <= tw_n + 1;
            if (cpu_req_valid && cpu_ready) acc_cyc <= cyc;
            if (cpu_resp_valid) begin
                resp_n <= resp_n + 1; resp_rdata <= cpu_rdata; resp_cyc <= cyc;
            end
        end
    end

    int tests = 0, fails = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int s_wb, s_fetch, s_fill, s_tw, s_mem;

    task automatic do_req(input logic rw, input logic [AW-1:0] a, input logic [W-1:0] wd,
                          input string name);
        int s_resp;
        s_wb = wb_n; s_fetch = fetch_n; s_fill = fill_n; s_tw = tw_n; s_mem = memcyc_n;
        s_resp = resp_n;
        cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        for (int i = 0; i < 200 && resp_n == s_resp; i++) begin
            @(posedge clk); #1;
        end
        if (resp_n == s_resp) check({name, "_timeout"}, 32'd0, 32'd1);
        $display("[TB] %s rw=%0b addr=0x%08h rdata=0x%02h lat=%0d wb=%0d fetch=%0d hit=%0d miss=%0d",
                 name, rw, a, resp_rdata, resp_cyc - acc_cyc, wb_n - s_wb, fetch_n - s_fetch,
                 hit_cnt, miss_cnt);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", cpu_ready, 1);
        check("rst_resp", cpu_resp_valid, 0);
        check("rst_memreq", mem_req, 0);
        check("rst_strobes", {line_try_read, line_try_write, line_cache_write, mem_we}, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_hit", hit_cnt, 0);
        check("rst_miss", miss_cnt, 0);
        rst_b = 1'b0;
        @(posedge clk); #1;

        mem_wait_cfg = 2; mem_fetch_data = 8'hA5;
        do_req(1'b0, 32'h0000_1000, 8'h00, "cold_read");
        check("cold_fetch_n", fetch_n - s_fetch, 1);
        check("cold_fetch_addr", fetch_addr, 32'h0000_1000);
        check("cold_wb_n", wb_n - s_wb, 0);
        check("cold_fill_n", fill_n - s_fill, 1);
        check("cold_rdata", resp_rdata, 8'hA5);
        check("cold_miss", miss_cnt, 1);
        check("cold_hit", hit_cnt, 0);

        do_req(1'b0, 32'h0000_1000, 8'h00, "hit_read");
        check("hitrd_mem", memcyc_n - s_mem, 0);
        check("hitrd_lat", resp_cyc - acc_cyc, 2);
        check("hitrd_rdata", resp_rdata, 8'hA5);
        check("hitrd_hit", hit_cnt, 1);

        do_req(1'b1, 32'h0000_1000, 8'h3C, "hit_write");
        check("hitwr_trywrite", tw_n - s_tw, 1);
        check("hitwr_dirty", ld, 1);
        check("hitwr_data", ldata, 8'h3C);
        check("hitwr_lat", resp_cyc - acc_cyc, 2);
        check("hitwr_mem", memcyc_n - s_mem, 0);
        check("hitwr_hit", hit_cnt, 2);

        mem_wait_cfg = 1; mem_fetch_data = 8'h5A;
        do_req(1'b0, 32'h8000_1000, 8'h00, "dirty_read");
        check("dirty_wb_n", wb_n - s_wb, 1);
        check("dirty_wb_addr", wb_addr, 32'h0000_1000);
        check("dirty_wb_data", wb_data, 8'h3C);
        check("dirty_fetch_n", fetch_n - s_fetch, 1);
        check("dirty_fetch_addr", fetch_addr, 32'h8000_1000);
        check("dirty_order", wb_cyc < fetch_cyc, 1);
        check("dirty_rdata", resp_rdata, 8'h5A);
        check("dirty_miss", miss_cnt, 2);
        check("dirty_hit", hit_cnt, 2);

        mem_wait_cfg = 0; mem_fetch_data = 8'h99;
        do_req(1'b1, 32'h4000_0000, 8'h77, "write_miss_zw");
        check("wmiss_wb_n", wb_n - s_wb, 0);
        check("wmiss_fetch_n", fetch_n - s_fetch, 1);
        check("wmiss_data", ldata, 8'h77);
        check("wmiss_dirty", ld, 1);
        check("wmiss_miss", miss_cnt, 3);
        check("wmiss_hit", hit_cnt, 2);

        // Park a write-back indefinitely, then reset in the middle of it.
        mem_wait_cfg = 100000;
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_addr = 32'h0000_2000;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        for (int i = 0; i < 20 && !(mem_req && mem_we); i++) begin
            @(posedge clk); #1;
        end
        check("wb_reached", mem_req && mem_we, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        $display("[TB] reset_in_writeback mem_req=%0b ready=%0b hit=%0d miss=%0d",
                 mem_req, cpu_ready, hit_cnt, miss_cnt);
        check("wbrst_memreq", mem_req, 0);
        check("wbrst_ready", cpu_ready, 1);
        check("wbrst_hit", hit_cnt, 0);
        check("wbrst_miss", miss_cnt, 0);
        rst_b = 1'b0;
        mem_wait_cfg = 1; mem_fetch_data = 8'h11;
        @(posedge clk); #1;

        do_req(1'b0, 32'h0000_3000, 8'h00, "post_reset_read");
        check("postrst_fetch_addr", fetch_addr, 32'h0000_3000);
        check("postrst_wb_n", wb_n - s_wb, 0);
        check("postrst_rdata", resp_rdata, 8'h11);
        check("postrst_miss", miss_cnt, 1);
        check("postrst_hit", hit_cnt, 0);

        for (int n = 0; n < 255; n++) do_req(1'b0, 32'h0000_3000, 8'h00, "sat_fill_hit");
        check("sat_reach", hit_cnt, 8'hFF);
        do_req(1'b0, 32'h0000_3000, 8'h00, "sat_extra_hit");
        check("sat_hold", hit_cnt, 8'hFF);
        check("sat_rdata", resp_rdata, 8'h11);
        check("sat_miss", miss_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
